axi_burst_master: RTL
=====================

// Module: axi_burst_master
// PURPOSE
//  Command-driven AXI4 master; the stage directly upstream of axi_slave on one axi_if.
//  - Converts one {write/read, addr, len} command into a single INCR burst.
//  - Takes write beats from a valid/ready stream and returns read beats on another.
//  - Reports BRESP/RRESP status with a one-cycle done pulse.
// PARAMETERS
//  MAX_LEN        16    max beats per burst; legal cmd_len = 0..MAX_LEN-1
//  AXI_ID         0     constant AWID/ARID value
//  TIMEOUT_CYCLES 1024  watchdog limit, used only with AXI_MASTER_TIMEOUT_EN
// PORTS
//  clk        in   1      clock; all logic on posedge
//  rst_n      in   1      asynchronous active-low reset
//  axi        axi_if.master  -      AXI4 master side (AW, W, B, AR, R channels)
//  cmd_valid  in   1      command valid
//  cmd_ready  out  1      command accepted when valid&&ready; high only in IDLE
//  cmd_write  in   1      1 = write burst, 0 = read burst
//  cmd_addr   in   `AXI_ADDR_WIDTH  start byte address
//  cmd_len    in   8      beats-1 (AxLEN encoding)
//  wr_data    in   `AXI_DATA_WIDTH  write beat data
//  wr_valid   in   1      write beat valid
//  wr_ready   out  1      write beat consumed (= WREADY in ST_W)
//  rd_data    out  `AXI_DATA_WIDTH  read beat data (= RDATA)
//  rd_valid   out  1      read beat valid (= RVALID in ST_R)
//  rd_last    out  1      final read beat (= RLAST)
//  rd_ready   in   1      read sink ready (drives RREADY in ST_R)
//  done       out  1      one-cycle pulse: command complete
//  resp       out  2      status, valid while done=1; held until next done
//  busy       out  1      high in every state except IDLE
//  timeout    out  1      one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset values
//  - AWVALID, WVALID, ARVALID, BREADY, RREADY, done, busy, timeout = 0.
//  - resp = 2'b00; beat counter = 0; state = IDLE; cmd_ready = 1.
//  FSM states: IDLE, REJ, AW, W, B, AR, R.
//  - IDLE accept, cmd_len >= MAX_LEN -> REJ: no AXI traffic; next cycle done=1, resp=2'b10, back to IDLE.
//  - IDLE accept, write -> AW; read -> AR.
//  - Address/len/write are captured at accept.
//  - First VALID is asserted the cycle after accept.
//  - AW/AR channel values: AxADDR = addr, AxLEN = len, AxSIZE = log2(DW/8), AxBURST = INCR, AxID = AXI_ID.
//  - AW/AR: VALID held with stable payload until READY; then -> W or R.
//  - W: WVALID = wr_valid, WDATA = wr_data, WSTRB = all ones, WLAST = (beat == len).
//    - Beat counter increments on each WVALID&&WREADY.
//    - The last-beat handshake -> B.
//  - B: BREADY = 1; on BVALID, resp <= BRESP, done pulses, -> IDLE.
//  - R: rd_* pass-through; RREADY = rd_ready.
//    - resp accumulates the max RRESP over all beats.
//    - On RLAST handshake: done pulses, -> IDLE.
//    - RLAST with beat != len forces resp = 2'b10.
//  - done and cmd_ready are both high in the IDLE-entry cycle, so back-to-back commands incur zero bubble.
//  - No VALID ever depends combinationally on the matching READY.
//  - Beat counter is 8 bits and cannot wrap because len <= MAX_LEN-1 <= 255.
//  - Reset mid-burst: all VALIDs drop asynchronously and the burst is abandoned; the slave is reset with it.
// CONFIGURATION
//  AXI_MASTER_TIMEOUT_EN defined
//  - Counter runs in AW/W/B/AR/R and clears on every channel handshake.
//  - On reaching TIMEOUT_CYCLES: all VALID/READY drop, done=1, timeout=1, resp=2'b11, -> IDLE.
//  AXI_MASTER_TIMEOUT_EN undefined
//  - No counter; timeout tied 0; the FSM waits indefinitely.
// TESTING
//  - Reset: rst_n=0 with clk running -> all VALIDs 0, busy=0; after release cmd_ready=1.
//  - Single write then read:
//    - Write addr 0x100, len 0, data 0xDEADBEEF -> AWLEN=0, one W beat with WLAST=1, done with resp=00.
//    - Read 0x100 -> rd_data=0xDEADBEEF, rd_last=1.
//  - Burst with throttling:
//    - Write 0x200, len 3, data 1..4, with wr_valid gaps and random WREADY -> WLAST only on beat 4.
//    - Read len 3 with rd_ready toggling -> 1,2,3,4 in order, rd_last on 4th.
//  - Reject: cmd_len=16 (MAX_LEN=16) -> no AWVALID/ARVALID; done next cycle with resp=10.
//  - Reset mid-W after 2 beats -> WVALID drops in the same cycle; after release, a new write 0x300 len 0 completes with OKAY.
//  - Timeout, macro on, TIMEOUT_CYCLES=32, slave withholds BVALID -> done=timeout=1 32 cycles after entering B, resp=11.
//  - Timeout, macro off, same stimulus -> busy stays 1 and timeout stays 0.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// AXI4 bus bundle shared by axi_burst_master (master side) and axi_slave (slave side).
// Widths come from AXI_ADDR_WIDTH / AXI_DATA_WIDTH / AXI_ID_WIDTH.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

interface axi_if;
  logic [`AXI_ID_WIDTH-1:0]     awid;
  logic [`AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                   awlen;
  logic [2:0]                   awsize;
  logic [1:0]                   awburst;
  logic                         awvalid;
  logic                         awready;
  logic [`AXI_DATA_WIDTH-1:0]   wdata;
  logic [`AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                         wlast;
  logic                         wvalid;
  logic                         wready;
  logic [`AXI_ID_WIDTH-1:0]     bid;
  logic [1:0]                   bresp;
  logic                         bvalid;
  logic                         bready;
  logic [`AXI_ID_WIDTH-1:0]     arid;
  logic [`AXI_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                   arlen;
  logic [2:0]                   arsize;
  logic [1:0]                   arburst;
  logic                         arvalid;
  logic                         arready;
  logic [`AXI_ID_WIDTH-1:0]     rid;
  logic [`AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                   rresp;
  logic                         rlast;
  logic                         rvalid;
  logic                         rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Command-driven AXI4 master: each {write/read, addr, len} command becomes one INCR burst.
// Define AXI_MASTER_TIMEOUT_EN to enable the per-channel watchdog.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi_burst_master #(
  parameter int MAX_LEN        = 16,
  parameter int AXI_ID         = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  axi_if.master                      axi,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [`AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]                 cmd_len,
  input  logic [`AXI_DATA_WIDTH-1:0] wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [`AXI_DATA_WIDTH-1:0] rd_data,
  output logic                       rd_valid,
  output logic                       rd_last,
  input  logic                       rd_ready,
  output logic                       done,
  output logic [1:0]                 resp,
  output logic                       busy,
  output logic                       timeout
);
  localparam logic [8:0]               MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [2:0]               AXSIZE    = 3'($clog2(`AXI_DATA_WIDTH / 8));
  localparam logic [`AXI_ID_WIDTH-1:0] AXID      = `AXI_ID_WIDTH'(AXI_ID);

  typedef enum logic [2:0] {S_IDLE, S_REJ, S_AW, S_W, S_B, S_AR, S_R} state_t;

  state_t                     state, state_nxt;
  logic [`AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                 len_q;
  logic [7:0]                 beat;
  logic [1:0]                 racc;
  logic                       cmd_hs, len_bad, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, expire;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign cmd_hs  = cmd_valid && (state == S_IDLE);
  assign len_bad = {1'b0, cmd_len} >= MAX_LEN_W;
  assign aw_hs   = (state == S_AW) && axi.awready;
  assign w_hs    = (state == S_W) && wr_valid && axi.wready;
  assign b_hs    = (state == S_B) && axi.bvalid;
  assign ar_hs   = (state == S_AR) && axi.arready;
  assign r_hs    = (state == S_R) && axi.rvalid && rd_ready;
  assign any_hs  = aw_hs || w_hs || b_hs || ar_hs || r_hs;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;

  // Watchdog restarts on every channel handshake, so it bounds each individual wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    wd_cnt <= '0;
    else if (state == S_IDLE || state == S_REJ || any_hs) wd_cnt <= '0;
    else                                           wd_cnt <= wd_cnt + 1'b1;
  end

  assign expire = (state inside {S_AW, S_W, S_B, S_AR, S_R}) && !any_hs &&
                  (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (expire) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (cmd_valid) state_nxt = len_bad ? S_REJ : (cmd_write ? S_AW : S_AR);
        S_REJ:   state_nxt = S_IDLE;
        S_AW:    if (aw_hs) state_nxt = S_W;
        S_W:     if (w_hs && beat == len_q) state_nxt = S_B;
        S_B:     if (b_hs) state_nxt = S_IDLE;
        S_AR:    if (ar_hs) state_nxt = S_R;
        S_R:     if (r_hs && axi.rlast) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      addr_q <= cmd_addr;
      len_q  <= cmd_len;
    end
  end

  // done lands in the first IDLE cycle, alongside cmd_ready, so commands can chain with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat    <= '0;
      racc    <= '0;
      resp    <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= expire;
      if (cmd_hs)             beat <= '0;
      else if (w_hs || r_hs)  beat <= beat + 8'd1;
      if (cmd_hs)             racc <= '0;
      else if (r_hs)          racc <= resp_max(racc, axi.rresp);
      if (expire) begin
        done <= 1'b1;
        resp <= 2'b11;
      end else if (cmd_hs && len_bad) begin
        done <= 1'b1;
        resp <= 2'b10;
      end else if (b_hs) begin
        done <= 1'b1;
        resp <= axi.bresp;
      end else if (r_hs && axi.rlast) begin
        done <= 1'b1;
        resp <= (beat != len_q) ? 2'b10 : resp_max(racc, axi.rresp);
      end
    end
  end

  always_comb begin
    axi.awid    = AXID;
    axi.awaddr  = addr_q;
    axi.awlen   = len_q;
    axi.awsize  = AXSIZE;
    axi.awburst = 2'b01;
    axi.awvalid = (state == S_AW);
    axi.wdata   = wr_data;
    axi.wstrb   = '1;
    axi.wlast   = (beat == len_q);
    axi.wvalid  = (state == S_W) && wr_valid;
    axi.bready  = (state == S_B);
    axi.arid    = AXID;
    axi.araddr  = addr_q;
    axi.arlen   = len_q;
    axi.arsize  = AXSIZE;
    axi.arburst = 2'b01;
    axi.arvalid = (state == S_AR);
    axi.rready  = (state == S_R) && rd_ready;
    cmd_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    wr_ready    = (state == S_W) && axi.wready;
    rd_data     = axi.rdata;
    rd_valid    = (state == S_R) && axi.rvalid;
    rd_last     = axi.rlast;
  end
endmodule
